// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Turns a decoded instruction request (kind + register/immediate/target fields)
// into a 32-bit MIPS instruction word. Each word is tagged with the byte address
// it should be written to. The word then passes through a 2-entry FIFO towards
// an instruction-memory writer.
//
// Configuration macro: IENC_ILLEGAL_TRAP_EN
//   defined   : illegal kinds (10-15) are consumed without being pushed, do not
//               advance the address, and set the sticky err flag.
//   undefined : illegal kinds encode as a NOP (32'h0), are pushed normally, and
//               err is tied low.
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   in_valid/ready  request handshake; in_ready is registered (occupancy < 2)
//   in_kind         0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 LW,6 SW,7 BEQ,8 ADDI,9 J
//   in_rs/rt/rd     register fields
//   in_imm          immediate / branch offset
//   in_target       jump target field
//   out_valid/ready word handshake towards the memory writer
//   out_instr       encoded word at the FIFO head (32'h0 when empty)
//   out_addr        byte address of out_instr (32'h0 when empty)
//   out_count       number of words delivered, wraps at 16 bits
//   err             sticky illegal-kind flag (trap build only)
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [15:0] out_count,
  output logic        err
);

  // Builds the instruction word; unknown kinds give the all-zero NOP.
  function automatic logic [31:0] encode_word(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    case (kind)
      4'd0:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    word = {6'b100011, rs, rt, imm};
      4'd6:    word = {6'b101011, rs, rt, imm};
      4'd7:    word = {6'b000100, rs, rt, imm};
      4'd8:    word = {6'b001000, rs, rt, imm};
      4'd9:    word = {6'b000010, target};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

`ifdef IENC_ILLEGAL_TRAP_EN
  // Kinds above J have no encoding.
  function automatic logic is_legal(input logic [3:0] kind);
    return (kind <= 4'd9);
  endfunction
`endif

  // FIFO storage: the head entry drives the outputs directly, and the tail
  // holds the second word when two are buffered.
  logic [1:0]  count_r;
  logic [1:0]  count_nxt_s;
  logic [31:0] head_instr_r;
  logic [31:0] head_addr_r;
  logic [31:0] tail_instr_r;
  logic [31:0] tail_addr_r;
  logic [31:0] next_addr_r;
  logic [15:0] out_count_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:0] word_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;

  // Handshake decode and next occupancy.
  always_comb begin
    word_s   = encode_word(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
    accept_s = in_valid && in_ready_r;
    pop_s    = out_valid_r && out_ready;
`ifdef IENC_ILLEGAL_TRAP_EN
    push_s   = accept_s && is_legal(in_kind);
`else
    push_s   = accept_s;
`endif
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO, address counter and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r      <= 2'd0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      head_instr_r <= 32'h0000_0000;
      head_addr_r  <= 32'h0000_0000;
      tail_instr_r <= 32'h0000_0000;
      tail_addr_r  <= 32'h0000_0000;
      next_addr_r  <= BASE_ADDR;
      out_count_r  <= 16'h0000;
    end else begin
      count_r     <= count_nxt_s;
      // Readiness flags are registered copies of the next occupancy, so
      // in_ready never depends combinationally on out_ready.
      in_ready_r  <= (count_nxt_s < 2'd2);
      out_valid_r <= (count_nxt_s != 2'd0);

      if (push_s) begin
        next_addr_r <= next_addr_r + 32'd4;
      end else begin
        next_addr_r <= next_addr_r;
      end

      if (pop_s) begin
        out_count_r <= out_count_r + 16'd1;
      end else begin
        out_count_r <= out_count_r;
      end

      // The new word lands in the head when the FIFO is empty, or when the
      // single buffered word leaves in the same cycle.
      if (push_s && ((count_r == 2'd0) || pop_s)) begin
        head_instr_r <= word_s;
        head_addr_r  <= next_addr_r;
      end else if (pop_s && (count_r == 2'd2)) begin
        head_instr_r <= tail_instr_r;
        head_addr_r  <= tail_addr_r;
      end else if (pop_s) begin
        // The FIFO drains to empty, so the outputs return to zero.
        head_instr_r <= 32'h0000_0000;
        head_addr_r  <= 32'h0000_0000;
      end else begin
        head_instr_r <= head_instr_r;
        head_addr_r  <= head_addr_r;
      end

      if (push_s && !pop_s && (count_r == 2'd1)) begin
        tail_instr_r <= word_s;
        tail_addr_r  <= next_addr_r;
      end else begin
        tail_instr_r <= tail_instr_r;
        tail_addr_r  <= tail_addr_r;
      end
    end
  end

`ifdef IENC_ILLEGAL_TRAP_EN
  logic err_r;

  // Sticky illegal-kind flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (accept_s && !is_legal(in_kind)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_instr = head_instr_r;
  assign out_addr  = head_addr_r;
  assign out_count = out_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. A queue-based reference model tracks
// the expected FIFO contents, address counter, delivered count and err flag.
// The model's encoder is built from opcode/funct lookup tables. The bench runs
// directed vectors, stall, illegal-kind and reset scenarios, random traffic,
// and a 16-bit out_count wrap.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef IENC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [15:0] out_count;
  logic        err;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .out_count(out_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  entry_t      mq[$];
  logic [31:0] m_addr;
  logic [15:0] m_count;
  logic        m_err;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [5:0] functs [0:4] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [5:0] iops   [0:3] = '{6'h23, 6'h2B, 6'h04, 6'h08};

  // Reference encoder built from the opcode/funct tables.
  function automatic logic [31:0] ref_enc(input logic [3:0] k, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] target);
    int ki;
    ki = int'(k);
    if (ki < 5)
      return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(functs[ki]);
    else if (ki < 9)
      return (32'(iops[ki-5]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    else if (ki == 9)
      return (32'd2 << 26) | 32'(target);
    else
      return 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] ei;
    logic [31:0] ea;
    ei = 32'h0;
    ea = 32'h0;
    if (mq.size() > 0) begin
      ei = mq[0].instr;
      ea = mq[0].addr;
    end
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("out_instr", out_instr, ei);
    chk("out_addr", out_addr, ea);
    chk("out_count", 32'(out_count), 32'(m_count));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic model_reset();
    mq.delete();
    m_addr  = BASE;
    m_count = 16'h0;
    m_err   = 1'b0;
  endtask

  // One clock cycle: predict the handshakes, step the clock, update the model, check.
  task automatic cycle();
    bit acc;
    bit pop;
    acc = in_valid && (mq.size() < 2) && !rst;
    pop = (mq.size() > 0) && out_ready && !rst;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(mq.pop_front());
      m_count = m_count + 16'd1;
    end
    if (acc) begin
      if ((in_kind <= 4'd9) || !TRAP) begin
        mq.push_back('{instr: ref_enc(in_kind, in_rs, in_rt, in_rd, in_imm, in_target),
                       addr: m_addr});
        m_addr = m_addr + 32'd4;
      end else begin
        m_err = 1'b1;
      end
    end
    check_all();
  endtask

  task automatic set_in(input logic v, input logic [3:0] k, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] target);
    in_valid  = v;
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = target;
  endtask

  // Reset pulse placed between clock edges; requests offered meanwhile are dropped.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'd0, 5'd1,  5'd2, 5'd3,  16'h0000, 26'h0, 32'h0022_1820};
    vecs[1] = '{4'd1, 5'd1,  5'd2, 5'd3,  16'h0000, 26'h0, 32'h0022_1822};
    vecs[2] = '{4'd2, 5'd1,  5'd2, 5'd3,  16'h0000, 26'h0, 32'h0022_1824};
    vecs[3] = '{4'd3, 5'd1,  5'd2, 5'd3,  16'h0000, 26'h0, 32'h0022_1825};
    vecs[4] = '{4'd4, 5'd1,  5'd2, 5'd3,  16'h0000, 26'h0, 32'h0022_182A};
    vecs[5] = '{4'd5, 5'd29, 5'd8, 5'd31, 16'h0004, 26'h0, 32'h8FA8_0004};
    vecs[6] = '{4'd7, 5'd4,  5'd5, 5'd0,  16'hFFFF, 26'h0, 32'h1085_FFFF};
    vecs[7] = '{4'd9, 5'd7,  5'd9, 5'd11, 16'hABCD, 26'h0000010, 32'h0800_0010};
    vecs[8] = '{4'd6, 5'd29, 5'd8, 5'd0,  16'h0004, 26'h0, 32'hAFA8_0004};
    vecs[9] = '{4'd8, 5'd1,  5'd2, 5'd0,  16'h1234, 26'h0, 32'h2022_1234};

    // Reset held with a request offered: the request must be discarded.
    rst       = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_instr", out_instr, 32'h0);
    rst = 1'b0;
    set_in(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    cycle();

    // Directed encodings, one word at a time, out_ready high.
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm,
             vecs[i].target);
      cycle();
      chk("vec_instr", out_instr, vecs[i].exp);
      chk("vec_addr", out_addr, 32'(i * 4));
      in_valid = 1'b0;
      cycle();
      chk("vec_count", 32'(out_count), 32'(i + 1));
    end

    // Stall: three back-to-back requests with out_ready low.
    do_reset();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      set_in(1'b1, vecs[j].kind, vecs[j].rs, vecs[j].rt, vecs[j].rd, vecs[j].imm,
             vecs[j].target);
      cycle();
    end
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    chk("stall_head_addr", out_addr, 32'h0);
    chk("stall_head_instr", out_instr, vecs[0].exp);
    out_ready = 1'b1;
    cycle();
    chk("stall_second_addr", out_addr, 32'h4);
    cycle();
    in_valid = 1'b0;
    chk("stall_third_addr", out_addr, 32'h8);
    chk("stall_third_instr", out_instr, vecs[2].exp);
    cycle();
    cycle();

    // Illegal kind followed by ADD.
    do_reset();
    out_ready = 1'b0;
    set_in(1'b1, 4'd15, 5'd1, 5'd2, 5'd3, 16'h5555, 26'h1);
    cycle();
    set_in(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    cycle();
    in_valid = 1'b0;
`ifdef IENC_ILLEGAL_TRAP_EN
    chk("trap_err", 32'(err), 32'h1);
    chk("trap_add_instr", out_instr, 32'h0022_1820);
    chk("trap_add_addr", out_addr, 32'h0);
`else
    chk("nop_err", 32'(err), 32'h0);
    chk("nop_instr", out_instr, 32'h0);
    chk("nop_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    cycle();
    chk("nop_add_instr", out_instr, 32'h0022_1820);
    chk("nop_add_addr", out_addr, 32'h4);
`endif
    out_ready = 1'b1;
    cycle();
    cycle();

    // Asynchronous reset mid-cycle with two words buffered.
    out_ready = 1'b0;
    set_in(1'b1, 4'd1, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0);
    cycle();
    cycle();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_count", 32'(out_count), 32'h0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    set_in(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    cycle();
    in_valid = 1'b0;
    chk("post_reset_addr", out_addr, BASE);
    out_ready = 1'b1;
    cycle();

    // Random traffic against the model.
    for (int r = 0; r < 600; r++) begin
      set_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 5'($urandom),
             5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      out_ready = 1'($urandom_range(0, 3) != 0);
      cycle();
    end

    // Continuous streaming to wrap out_count past 16'hFFFF.
    do_reset();
    out_ready = 1'b1;
    set_in(1'b1, 4'd3, 5'd6, 5'd7, 5'd8, 16'h0, 26'h0);
    for (int w = 0; w < 65540; w++) begin
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("count_wrap", 32'(out_count), 32'(m_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
